// File: rtl/shadow_chain_rx.sv
`default_nettype none
// ============================================================================
//  Module      : shadow_chain_rx
//  Description : Sequentially dumps up to eight serial shadow chains, packs
//                each chain's LSB-first bit stream into WORD_W-bit words
//                tagged with the source chain index, and queues them in a
//                small output FIFO with valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module shadow_chain_rx #(
  parameter int CHAINS     = 5,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sh_clk,
  input  logic              sh_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CHAINS-1:0] dump_en,
  input  logic [CHAINS-1:0] ch_out,
  input  logic [CHAINS-1:0] ch_out_vld,
  input  logic [CHAINS-1:0] ch_out_done,
  output logic [WORD_W-1:0] rd_data,
  output logic [2:0]        rd_chain,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic              err_partial
);

  localparam int c_BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_EW = WORD_W + 3;
  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(WORD_W - 1);
  localparam logic [c_AW:0]   c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [2:0]      c_LAST     = 3'(CHAINS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_ADV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_idx;
  logic [2:0]          w_idx_nxt;
  logic [c_BW-1:0]     r_bitcnt;
  logic [WORD_W-1:0]   r_shift;
  logic                r_stg_vld;
  logic [WORD_W-1:0]   r_stg_data;
  logic [2:0]          r_stg_chain;
  logic [c_EW-1:0]     r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]     r_wp;
  logic [c_AW-1:0]     r_rp;
  logic [c_AW:0]       r_cnt;
  logic                r_err;

  logic [CHAINS-1:0]   w_sel;
  logic                w_in_dump;
  logic                w_bit_vld;
  logic                w_bit;
  logic                w_chain_done;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_stg_free;
  logic [WORD_W-1:0]   w_word;
  logic                w_word_last;
  logic [c_BW-1:0]     w_bitcnt_acc;
  logic [WORD_W-1:0]   w_shift_acc;
  logic                w_partial;
  logic                w_partial_take;
  logic                w_done_take;
  logic                w_stg_load;
  logic [WORD_W-1:0]   w_stg_load_data;
  logic [c_EW-1:0]     w_head;

  // Only the selected chain's strobes are ever looked at.
  assign w_sel        = CHAINS'(1) << r_idx;
  assign w_in_dump    = (r_state == ST_DUMP);
  assign w_bit_vld    = w_in_dump && |(ch_out_vld & w_sel);
  assign w_bit        = |(ch_out & w_sel);
  assign w_chain_done = w_in_dump && |(ch_out_done & w_sel);

  assign w_full     = (r_cnt == c_DEPTH);
  assign w_empty    = (r_cnt == '0);
  assign w_push     = r_stg_vld && !w_full;
  assign w_pop      = !w_empty && rd_rdy;
  // Staging can take a new word if it is empty or draining this cycle.
  assign w_stg_free = !r_stg_vld || w_push;

  // Bit acceptance happens first; chain-done then sees the updated count.
  assign w_word       = r_shift | (WORD_W'(w_bit) << r_bitcnt);
  assign w_word_last  = w_bit_vld && (r_bitcnt == c_BIT_LAST);
  assign w_bitcnt_acc = w_bit_vld ? (w_word_last ? '0 : r_bitcnt + 1'b1) : r_bitcnt;
  assign w_shift_acc  = w_bit_vld ? (w_word_last ? '0 : w_word) : r_shift;

  // A partial word waits for a free staging slot; done is a level, so it
  // is simply re-evaluated next cycle.
  assign w_partial       = w_chain_done && (w_bitcnt_acc != '0);
  assign w_partial_take  = w_partial && w_stg_free;
  assign w_done_take     = w_chain_done && (!w_partial || w_stg_free);
  assign w_stg_load      = w_word_last || w_partial_take;
  assign w_stg_load_data = w_word_last ? w_word : w_shift_acc;

  assign w_head      = r_mem[r_rp];
  assign rd_vld      = !w_empty;
  assign rd_data     = w_empty ? '0 : w_head[WORD_W-1:0];
  assign rd_chain    = w_empty ? '0 : w_head[c_EW-1 -: 3];
  assign err_partial = r_err;

  // State and chain index registers.
  always_ff @(posedge sh_clk) begin
    if (sh_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state decode plus dump enable, busy and done outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    busy        = 1'b1;
    done        = 1'b0;
    dump_en     = '0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = ST_DUMP;
          w_idx_nxt   = '0;
        end
      end
      ST_DUMP: begin
        if (!r_stg_vld && !w_full) begin
          dump_en = w_sel;
        end
        if (w_done_take) begin
          w_state_nxt = ST_ADV;
        end
      end
      ST_ADV: begin
        if (!r_stg_vld) begin
          if (r_idx == c_LAST) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = ST_DUMP;
          end
        end
      end
      ST_FIN: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Deserializer: shift register is cleared at each word boundary so a
  // partial word comes out zero-padded.
  always_ff @(posedge sh_clk) begin
    if (sh_rst) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (w_partial_take) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_bitcnt <= w_bitcnt_acc;
      r_shift  <= w_shift_acc;
    end
  end

  // Single-entry staging register between deserializer and FIFO.
  always_ff @(posedge sh_clk) begin
    if (sh_rst) begin
      r_stg_vld   <= 1'b0;
      r_stg_data  <= '0;
      r_stg_chain <= '0;
    end else if (w_stg_load) begin
      r_stg_vld   <= 1'b1;
      r_stg_data  <= w_stg_load_data;
      r_stg_chain <= r_idx;
    end else if (w_push) begin
      r_stg_vld   <= 1'b0;
    end
  end

  // FIFO storage; contents are qualified by the count so no reset needed.
  always_ff @(posedge sh_clk) begin
    if (w_push) begin
      r_mem[r_wp] <= {r_stg_chain, r_stg_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge sh_clk) begin
    if (sh_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky partial-word flag, cleared only by reset or a new dump.
  always_ff @(posedge sh_clk) begin
    if (sh_rst) begin
      r_err <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_err <= 1'b0;
    end else if (w_partial_take) begin
      r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire
